cordic_vector: RTL

//  Iterative vectoring-mode CORDIC: takes a Cartesian vector (x_in, y_in) and returns its magnitude and

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_vec_iter.sv | 40 ++++
 rtl/cordic_vector.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, used by cordic (rotation) and cordic_vector (vectoring).
//   - atan(2^-i) table, i = 0..16, Q.14 in an 18-bit signed word
//   - PI / PI_2 in the Q.14 angle accumulator format, PI in the Q3.13 output format
//   - K_INV: reciprocal CORDIC gain, Q1.14
//   - state_t: FSM state encoding for the iterative cores
package cordic_pkg;

   localparam int unsigned ZW = 18;

   localparam logic signed [ZW-1:0] PI_Z   = 18'sd51472;
   localparam logic signed [ZW-1:0] PI_2_Z = 18'sd25736;
   localparam logic signed [15:0]   PI_OUT = 16'sd25736;
   localparam logic signed [15:0]   K_INV  = 16'sd9949;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } state_t;

   function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] i);
      logic signed [ZW-1:0] a;
      case (i)
         5'd0:    a = 18'sd12868;
         5'd1:    a = 18'sd7596;
         5'd2:    a = 18'sd4014;
         5'd3:    a = 18'sd2037;
         5'd4:    a = 18'sd1023;
         5'd5:    a = 18'sd512;
         5'd6:    a = 18'sd256;
         5'd7:    a = 18'sd128;
         5'd8:    a = 18'sd64;
         5'd9:    a = 18'sd32;
         5'd10:   a = 18'sd16;
         5'd11:   a = 18'sd8;
         5'd12:   a = 18'sd4;
         5'd13:   a = 18'sd2;
         5'd14:   a = 18'sd1;
         default: a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/cordic_vec_iter.sv
// Single vectoring-mode micro-rotation (combinational).
// Drives y toward zero; z accumulates the rotated angle.
// Ports:
//   x, y, z              current vector / angle accumulator (IW-bit signed)
//   i                    iteration index (shift amount, atan table index)
//   x_next, y_next, z_next  rotated values, computed from pre-update x, y
module cordic_vec_iter
   import cordic_pkg::*;
#(
   parameter int unsigned IW = 18
) (
   input  logic signed [IW-1:0] x,
   input  logic signed [IW-1:0] y,
   input  logic signed [IW-1:0] z,
   input  logic        [4:0]    i,
   output logic signed [IW-1:0] x_next,
   output logic signed [IW-1:0] y_next,
   output logic signed [IW-1:0] z_next
);

   logic signed [IW-1:0] x_sh;
   logic signed [IW-1:0] y_sh;
   logic signed [IW-1:0] atan_i;

   always_comb begin
      x_sh   = x >>> i;
      y_sh   = y >>> i;
      atan_i = atan_lut(i);
      if (!y[IW-1]) begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + atan_i;
      end else begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - atan_i;
      end
   end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x_in, y_in) -> magnitude and atan2 angle.
// One micro-rotation per clock; done pulses N_ITER+1 cycles after start is taken.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, sampled only when idle
//   x_in, y_in      signed Q1.14 vector
//   mag_out         Q1.14 magnitude, >= 0, saturated
//   angle_out       Q3.13 angle in (-pi, +pi]
//   busy            high while a conversion is in flight
//   done            one-cycle pulse, outputs valid from this cycle
// Build option: define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K;
// otherwise mag_out is the raw (gain K) CORDIC x result.
module cordic_vector
   import cordic_pkg::*;
#(
   parameter int unsigned WL     = 16,
   parameter int unsigned FL     = 14,
   parameter int unsigned N_ITER = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [WL-1:0] x_in,
   input  logic signed [WL-1:0] y_in,
   output logic        [WL-1:0] mag_out,
   output logic signed [WL-1:0] angle_out,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned IW = WL + 2;

   if (N_ITER > FL + 1) begin : g_bad_n_iter
      $error("cordic_vector: N_ITER must not exceed FL+1");
   end

   localparam logic signed [IW-1:0] PI_OUT_Z = {{(IW-WL){1'b0}}, PI_OUT};

   state_t               state;
   logic [4:0]           iter;
   logic signed [IW-1:0] x_r, y_r, z_r;
   logic signed [IW-1:0] x_nx, y_nx, z_nx;
   logic signed [IW-1:0] x_ext, y_ext;
   logic signed [IW-1:0] px, py, pz;
   logic                 zero_in;
   logic signed [IW-1:0] z_rnd;
   logic signed [WL-1:0] angle_c;
   logic        [WL-1:0] mag_c;

   cordic_vec_iter #(.IW(IW)) u_iter (
      .x      (x_r),
      .y      (y_r),
      .z      (z_r),
      .i      (iter),
      .x_next (x_nx),
      .y_next (y_nx),
      .z_next (z_nx)
   );

   // Quadrant pre-rotation brings x >= 0 so the micro-rotations converge.
   always_comb begin
      x_ext = {{(IW-WL){x_in[WL-1]}}, x_in};
      y_ext = {{(IW-WL){y_in[WL-1]}}, y_in};
      if (!x_in[WL-1]) begin
         px = x_ext;
         py = y_ext;
         pz = '0;
      end else if (!y_in[WL-1]) begin
         px = y_ext;
         py = -x_ext;
         pz = PI_2_Z;
      end else begin
         px = -y_ext;
         py = x_ext;
         pz = -PI_2_Z;
      end
   end

   // Round Q.14 -> Q.13. Anything at or beyond +-pi is reported as +pi so the
   // output stays in (-pi, +pi] even with table-rounding overshoot.
   always_comb begin
      z_rnd = (z_r + IW'(1)) >>> 1;
      if (z_rnd >= PI_OUT_Z || z_rnd <= -PI_OUT_Z)
         angle_c = PI_OUT;
      else
         angle_c = z_rnd[WL-1:0];
   end

`ifdef CORDIC_GAIN_COMP_EN
   localparam int unsigned MW = IW + WL;
   localparam logic signed [MW-1:0] MAG_RND = MW'(1) <<< (FL - 1);
   logic signed [MW-1:0] prod;
   logic signed [MW-1:0] mag_wide;
   always_comb begin
      prod     = $signed({{WL{x_r[IW-1]}}, x_r}) * $signed({{IW{K_INV[WL-1]}}, K_INV});
      mag_wide = (prod + MAG_RND) >>> FL;
   end
`else
   localparam int unsigned MW = IW;
   logic signed [MW-1:0] mag_wide;
   always_comb mag_wide = x_r;
`endif

   localparam logic signed [MW-1:0] MAG_MAX = {{(MW-WL+1){1'b0}}, {(WL-1){1'b1}}};

   always_comb begin
      if (mag_wide[MW-1])
         mag_c = '0;
      else if (mag_wide > MAG_MAX)
         mag_c = MAG_MAX[WL-1:0];
      else
         mag_c = mag_wide[WL-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         iter      <= '0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         zero_in   <= 1'b0;
         mag_out   <= '0;
         angle_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x_r     <= px;
                  y_r     <= py;
                  z_r     <= pz;
                  zero_in <= (x_in == '0) && (y_in == '0);
                  iter    <= '0;
                  busy    <= 1'b1;
                  state   <= ST_ITER;
               end
            end
            ST_ITER: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               if (iter == 5'(N_ITER - 1))
                  state <= ST_DONE;
               else
                  iter <= iter + 5'd1;
            end
            ST_DONE: begin
               // A zero vector would otherwise report the summed atan table.
               mag_out   <= zero_in ? '0 : mag_c;
               angle_out <= zero_in ? '0 : angle_c;
               done      <= 1'b1;
               busy      <= 1'b0;
               iter      <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
